mem_bus_arbiter: RTL and testbench

//  Shares the single-port RAM between the EX/MEM data port (loads/stores) and the IF fetch port.

---
 rtl/mem_bus_arbiter_pkg.sv | 22 ++
 rtl/mem_bus_arbiter_pick.sv | 51 +++++
 rtl/mem_bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_pkg
//   Shared types and constants for the memory bus arbiter slice.
//   - arb_state_t : arbiter FSM state encoding (2 bits)
//   - FETCH_SIZE  : size code driven to the RAM for instruction fetches (word)
//   - starve_cnt_width : width of a saturating counter that must reach max_val
// -----------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_DWAIT = 2'd1,
        ARB_IWAIT = 2'd2
    } arb_state_t;

    localparam logic [2:0] FETCH_SIZE = 3'b010;

    function automatic int starve_cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_pick.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_pick
//   Winner selection for the arbiter's IDLE state, plus the starvation counter
//   that eventually forces a fetch grant when data keeps winning.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   d_req      : data port requesting
//   i_req      : fetch port requesting
//   gnt_fire   : the RAM accepted the request issued from IDLE this cycle
//   sel_d      : data port is the current winner
//   sel_i      : fetch port is the current winner
// -----------------------------------------------------------------------------
module mem_bus_arbiter_pick
    import mem_bus_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_req,
    input  logic i_req,
    input  logic gnt_fire,
    output logic sel_d,
    output logic sel_i
);

    localparam int CNT_W = starve_cnt_width(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    // Data wins by default; fetch only wins when it is alone or has been
    // passed over STARVE_MAX times in a row.
    assign starved = (starve_cnt == CNT_MAX);
    assign sel_i   = i_req & (~d_req | starved);
    assign sel_d   = d_req & ~sel_i;

    // The counter measures how long a pending fetch has been waiting, so it
    // forgets everything as soon as fetch stops asking or finally gets served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!i_req || (gnt_fire && sel_i)) begin
            starve_cnt <= '0;
        end else if (gnt_fire && sel_d && !starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares one single-port RAM between the EX/MEM data port and the IF fetch
//   port. One transaction may be outstanding; the response is routed back to
//   the port that issued it. A flushed fetch has its response swallowed.
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   d_req_i .. d_size_i : data request and its fields
//   d_gnt_o, d_rvalid_o, d_rdata_o : data accept pulse and response
//   i_req_i, i_addr_i, i_flush_i   : fetch request, PC, pipeline flush
//   i_gnt_o, i_rvalid_o, i_rdata_o : fetch accept pulse and response
//   ram_req_o .. ram_size_o        : request towards the RAM
//   ram_gnt_i, ram_rvalid_i, ram_rdata_i : RAM handshake and response
//   hold_flag_o         : stall request while a data access is unfinished
// -----------------------------------------------------------------------------
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    input  logic [2:0]        d_size_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    input  logic              i_flush_i,
    output logic              i_gnt_o,
    output logic              i_rvalid_o,
    output logic [DATA_W-1:0] i_rdata_o,
    output logic              ram_req_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    output logic [2:0]        ram_size_o,
    input  logic              ram_gnt_i,
    input  logic              ram_rvalid_i,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              hold_flag_o
);

    arb_state_t state;
    arb_state_t state_next;
    logic       discard;
    logic       discard_next;
    logic       sel_d;
    logic       sel_i;
    logic       gnt_fire;

    // A grant only counts when it answers a request we actually raised from
    // IDLE; a gnt seen while waiting for a response is ignored.
    assign gnt_fire = (state == ARB_IDLE) & (d_req_i | i_req_i) & ram_gnt_i;

    mem_bus_arbiter_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk      (clk),
        .rst_n    (rst_n),
        .d_req    (d_req_i),
        .i_req    (i_req_i),
        .gnt_fire (gnt_fire),
        .sel_d    (sel_d),
        .sel_i    (sel_i)
    );

    // State and discard registers. The RAM shares the reset, so nothing that
    // was in flight can come back after reset and the discard bit can clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARB_IDLE;
            discard <= 1'b0;
        end else begin
            state   <= state_next;
            discard <= discard_next;
        end
    end

    // Next-state, request mux and response demux. Everything is forced to
    // zero while reset is asserted, since IDLE alone would still forward the
    // raw request lines to the RAM.
    always_comb begin
        state_next   = state;
        discard_next = discard;
        d_gnt_o      = 1'b0;
        d_rvalid_o   = 1'b0;
        d_rdata_o    = '0;
        i_gnt_o      = 1'b0;
        i_rvalid_o   = 1'b0;
        i_rdata_o    = '0;
        ram_req_o    = 1'b0;
        ram_we_o     = 1'b0;
        ram_addr_o   = '0;
        ram_wdata_o  = '0;
        ram_size_o   = 3'b000;
        hold_flag_o  = 1'b0;

        if (rst_n) begin
            hold_flag_o = d_req_i | ((state == ARB_DWAIT) & ~ram_rvalid_i);

            case (state)
                ARB_IDLE: begin
                    ram_req_o = d_req_i | i_req_i;
                    if (sel_i) begin
                        ram_addr_o = i_addr_i;
                        ram_size_o = FETCH_SIZE;
                    end else if (sel_d) begin
                        ram_we_o    = d_we_i;
                        ram_addr_o  = d_addr_i;
                        ram_wdata_o = d_wdata_i;
                        ram_size_o  = d_size_i;
                    end
                    if (gnt_fire) begin
                        d_gnt_o = sel_d;
                        i_gnt_o = sel_i;
                        if (sel_i) begin
                            state_next   = ARB_IWAIT;
                            discard_next = i_flush_i;
                        end else begin
                            state_next = ARB_DWAIT;
                        end
                    end
                end

                ARB_DWAIT: begin
                    if (ram_rvalid_i) begin
                        d_rvalid_o = 1'b1;
                        d_rdata_o  = ram_rdata_i;
                        state_next = ARB_IDLE;
                    end
                end

                ARB_IWAIT: begin
                    if (ram_rvalid_i) begin
                        i_rvalid_o   = ~discard;
                        i_rdata_o    = discard ? '0 : ram_rdata_i;
                        state_next   = ARB_IDLE;
                        discard_next = 1'b0;
                    end else if (i_flush_i) begin
                        discard_next = 1'b1;
                    end
                end

                default: begin
                    state_next = ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Directed bench for mem_bus_arbiter: a cycle-by-cycle vector table for the
//   basic load/store/fetch paths, then hand-written sequences for starvation,
//   flushed fetches and reset in the middle of a data access.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    typedef struct packed {
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [2:0]  d_size;
        logic        i_req;
        logic [31:0] i_addr;
        logic        i_flush;
        logic        ram_gnt;
        logic        ram_rvalid;
        logic [31:0] ram_rdata;
    } in_t;

    typedef struct packed {
        logic        d_gnt;
        logic        d_rvalid;
        logic [31:0] d_rdata;
        logic        i_gnt;
        logic        i_rvalid;
        logic [31:0] i_rdata;
        logic        ram_req;
        logic        ram_we;
        logic [31:0] ram_addr;
        logic [31:0] ram_wdata;
        logic [2:0]  ram_size;
        logic        hold;
    } out_t;

    typedef struct packed {
        in_t  stim;
        out_t exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [2:0]  d_size_i;
    logic        d_gnt_o;
    logic        d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        i_req_i;
    logic [31:0] i_addr_i;
    logic        i_flush_i;
    logic        i_gnt_o;
    logic        i_rvalid_o;
    logic [31:0] i_rdata_o;
    logic        ram_req_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic [2:0]  ram_size_o;
    logic        ram_gnt_i;
    logic        ram_rvalid_i;
    logic [31:0] ram_rdata_i;
    logic        hold_flag_o;

    out_t dut_out;
    int   checks;
    int   errors;

    localparam int NUM_VECS = 18;
    vec_t vecs [NUM_VECS];

    mem_bus_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .d_req_i      (d_req_i),
        .d_we_i       (d_we_i),
        .d_addr_i     (d_addr_i),
        .d_wdata_i    (d_wdata_i),
        .d_size_i     (d_size_i),
        .d_gnt_o      (d_gnt_o),
        .d_rvalid_o   (d_rvalid_o),
        .d_rdata_o    (d_rdata_o),
        .i_req_i      (i_req_i),
        .i_addr_i     (i_addr_i),
        .i_flush_i    (i_flush_i),
        .i_gnt_o      (i_gnt_o),
        .i_rvalid_o   (i_rvalid_o),
        .i_rdata_o    (i_rdata_o),
        .ram_req_o    (ram_req_o),
        .ram_we_o     (ram_we_o),
        .ram_addr_o   (ram_addr_o),
        .ram_wdata_o  (ram_wdata_o),
        .ram_size_o   (ram_size_o),
        .ram_gnt_i    (ram_gnt_i),
        .ram_rvalid_i (ram_rvalid_i),
        .ram_rdata_i  (ram_rdata_i),
        .hold_flag_o  (hold_flag_o)
    );

    assign dut_out = {d_gnt_o, d_rvalid_o, d_rdata_o, i_gnt_o, i_rvalid_o, i_rdata_o,
                      ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_size_o, hold_flag_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mkIn(input logic d_req, input logic d_we, input logic [31:0] d_addr,
                                 input logic [31:0] d_wdata, input logic [2:0] d_size,
                                 input logic i_req, input logic [31:0] i_addr, input logic i_flush,
                                 input logic gnt, input logic rv, input logic [31:0] rdata);
        return {d_req, d_we, d_addr, d_wdata, d_size, i_req, i_addr, i_flush, gnt, rv, rdata};
    endfunction

    function automatic out_t mkOut(input logic d_gnt, input logic d_rv, input logic [31:0] d_rdata,
                                   input logic i_gnt, input logic i_rv, input logic [31:0] i_rdata,
                                   input logic r_req, input logic r_we, input logic [31:0] r_addr,
                                   input logic [31:0] r_wdata, input logic [2:0] r_size,
                                   input logic hold);
        return {d_gnt, d_rv, d_rdata, i_gnt, i_rv, i_rdata, r_req, r_we, r_addr, r_wdata, r_size, hold};
    endfunction

    task automatic applyStimulus(input in_t s);
        d_req_i      = s.d_req;
        d_we_i       = s.d_we;
        d_addr_i     = s.d_addr;
        d_wdata_i    = s.d_wdata;
        d_size_i     = s.d_size;
        i_req_i      = s.i_req;
        i_addr_i     = s.i_addr;
        i_flush_i    = s.i_flush;
        ram_gnt_i    = s.ram_gnt;
        ram_rvalid_i = s.ram_rvalid;
        ram_rdata_i  = s.ram_rdata;
    endtask

    task automatic checkOutput(input string name, input out_t exp);
        checks++;
        if (dut_out !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", name, dut_out, exp);
        end
    endtask

    // Drive one cycle's inputs on the falling edge and check the combinational
    // outputs shortly after, well away from the rising edge.
    task automatic stepCheck(input string name, input in_t s, input out_t exp);
        @(negedge clk);
        applyStimulus(s);
        #1;
        checkOutput(name, exp);
    endtask

    out_t zero_out;
    in_t  zero_in;

    initial begin
        checks   = 0;
        errors   = 0;
        zero_out = '0;
        zero_in  = '0;

        // Load 0x100, data returned the cycle after the grant.
        vecs[0]  = '{mkIn(1,0,32'h100,0,3'b010, 0,0,0, 1,0,0),
                     mkOut(1,0,0, 0,0,0, 1,0,32'h100,0,3'b010, 1)};
        vecs[1]  = '{mkIn(0,0,0,0,0, 0,0,0, 0,1,32'hDEADBEEF),
                     mkOut(0,1,32'hDEADBEEF, 0,0,0, 0,0,0,0,0, 0)};
        vecs[2]  = '{zero_in, zero_out};
        // Stray rvalid in IDLE, then a store that must still see IDLE routing.
        vecs[3]  = '{mkIn(0,0,0,0,0, 0,0,0, 0,1,32'h12345678), zero_out};
        vecs[4]  = '{mkIn(1,1,32'h104,32'hA5A5,3'b001, 0,0,0, 0,0,0),
                     mkOut(0,0,0, 0,0,0, 1,1,32'h104,32'hA5A5,3'b001, 1)};
        vecs[5]  = '{mkIn(1,1,32'h104,32'hA5A5,3'b001, 0,0,0, 1,0,0),
                     mkOut(1,0,0, 0,0,0, 1,1,32'h104,32'hA5A5,3'b001, 1)};
        // Gnt while waiting is ignored; hold stays up until the store ack.
        vecs[6]  = '{mkIn(0,0,0,0,0, 0,0,0, 1,0,0),
                     mkOut(0,0,0, 0,0,0, 0,0,0,0,0, 1)};
        vecs[7]  = '{mkIn(0,0,0,0,0, 0,0,0, 0,1,0),
                     mkOut(0,1,0, 0,0,0, 0,0,0,0,0, 0)};
        // Simultaneous requests: data first, then fetch.
        vecs[8]  = '{mkIn(1,0,32'h300,0,3'b010, 1,32'h400,0, 1,0,0),
                     mkOut(1,0,0, 0,0,0, 1,0,32'h300,0,3'b010, 1)};
        vecs[9]  = '{mkIn(0,0,0,0,0, 1,32'h400,0, 0,1,32'h11111111),
                     mkOut(0,1,32'h11111111, 0,0,0, 0,0,0,0,0, 0)};
        vecs[10] = '{mkIn(0,0,0,0,0, 1,32'h400,0, 1,0,0),
                     mkOut(0,0,0, 1,0,0, 1,0,32'h400,0,3'b010, 0)};
        vecs[11] = '{zero_in, zero_out};
        vecs[12] = '{mkIn(0,0,0,0,0, 0,0,0, 0,1,32'h13),
                     mkOut(0,0,0, 0,1,32'h13, 0,0,0,0,0, 0)};
        // Flush in IDLE with no grant does nothing; flush on the grant cycle
        // discards that fetch's response, and the next fetch is unaffected.
        vecs[13] = '{mkIn(0,0,0,0,0, 0,0,1, 0,0,0), zero_out};
        vecs[14] = '{mkIn(0,0,0,0,0, 1,32'h500,1, 1,0,0),
                     mkOut(0,0,0, 1,0,0, 1,0,32'h500,0,3'b010, 0)};
        vecs[15] = '{mkIn(0,0,0,0,0, 0,0,0, 0,1,32'hCAFE), zero_out};
        vecs[16] = '{mkIn(0,0,0,0,0, 1,32'h504,0, 1,0,0),
                     mkOut(0,0,0, 1,0,0, 1,0,32'h504,0,3'b010, 0)};
        vecs[17] = '{mkIn(0,0,0,0,0, 0,0,0, 0,1,32'hBEEF),
                     mkOut(0,0,0, 0,1,32'hBEEF, 0,0,0,0,0, 0)};

        // Reset with requests pending: every output must stay low.
        rst_n = 1'b0;
        applyStimulus(mkIn(1,1,32'h10,32'h20,3'b010, 1,32'h30,0, 1,1,32'h40));
        @(negedge clk);
        #1;
        checkOutput("reset_outputs", zero_out);

        @(negedge clk);
        applyStimulus(zero_in);
        rst_n = 1'b1;

        for (int v = 0; v < NUM_VECS; v++) begin
            stepCheck($sformatf("vec[%0d]", v), vecs[v].stim, vecs[v].exp);
        end

        // Both ports requesting continuously: fetch wins every fifth grant.
        for (int g = 0; g < 10; g++) begin
            logic        is_i;
            logic [31:0] da;
            logic [31:0] rd;
            is_i = (g == 4) || (g == 9);
            da   = 32'h1000 + 32'(g * 4);
            rd   = 32'hA000 + 32'(g);
            if (is_i)
                stepCheck($sformatf("starve_gnt[%0d]", g),
                          mkIn(1,0,da,0,3'b010, 1,32'h2000,0, 1,0,0),
                          mkOut(0,0,0, 1,0,0, 1,0,32'h2000,0,3'b010, 1));
            else
                stepCheck($sformatf("starve_gnt[%0d]", g),
                          mkIn(1,0,da,0,3'b010, 1,32'h2000,0, 1,0,0),
                          mkOut(1,0,0, 0,0,0, 1,0,da,0,3'b010, 1));
            if (is_i)
                stepCheck($sformatf("starve_rsp[%0d]", g),
                          mkIn(1,0,da,0,3'b010, 1,32'h2000,0, 0,1,rd),
                          mkOut(0,0,0, 0,1,rd, 0,0,0,0,0, 1));
            else
                stepCheck($sformatf("starve_rsp[%0d]", g),
                          mkIn(1,0,da,0,3'b010, 1,32'h2000,0, 0,1,rd),
                          mkOut(0,1,rd, 0,0,0, 0,0,0,0,0, 1));
        end

        // Flush while the fetch is outstanding, response arrives two cycles later.
        stepCheck("flush_gnt", mkIn(0,0,0,0,0, 1,32'h1F0,0, 1,0,0),
                  mkOut(0,0,0, 1,0,0, 1,0,32'h1F0,0,3'b010, 0));
        stepCheck("flush_iwait", mkIn(0,0,0,0,0, 0,0,1, 0,0,0), zero_out);
        stepCheck("flush_wait2", zero_in, zero_out);
        stepCheck("flush_dropped", mkIn(0,0,0,0,0, 0,0,0, 0,1,32'h99), zero_out);
        stepCheck("refetch_gnt", mkIn(0,0,0,0,0, 1,32'h200,0, 1,0,0),
                  mkOut(0,0,0, 1,0,0, 1,0,32'h200,0,3'b010, 0));
        stepCheck("refetch_rsp", mkIn(0,0,0,0,0, 0,0,0, 0,1,32'h00100073),
                  mkOut(0,0,0, 0,1,32'h00100073, 0,0,0,0,0, 0));

        // Reset in the middle of a data access.
        stepCheck("mid_gnt", mkIn(1,0,32'h600,0,3'b010, 0,0,0, 1,0,0),
                  mkOut(1,0,0, 0,0,0, 1,0,32'h600,0,3'b010, 1));
        stepCheck("mid_dwait", zero_in, mkOut(0,0,0, 0,0,0, 0,0,0,0,0, 1));
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus(mkIn(1,1,32'h700,32'h55,3'b000, 1,32'h800,0, 1,1,32'hFFFF));
        #1;
        checkOutput("mid_reset", zero_out);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(mkIn(1,1,32'h700,32'h55,3'b000, 0,0,0, 0,0,0));
        #1;
        checkOutput("post_reset_req", mkOut(0,0,0, 0,0,0, 1,1,32'h700,32'h55,3'b000, 1));
        stepCheck("post_reset_gnt", mkIn(1,1,32'h700,32'h55,3'b000, 0,0,0, 1,0,0),
                  mkOut(1,0,0, 0,0,0, 1,1,32'h700,32'h55,3'b000, 1));
        stepCheck("post_reset_ack", mkIn(0,0,0,0,0, 0,0,0, 0,1,0),
                  mkOut(0,1,0, 0,0,0, 0,0,0,0,0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
